// File: rtl/dmem_if.sv
// Data-bus bundle between the MEM stage (master) and the data-memory responder (slave).
// Handshake: the master holds dreq and every request field stable from the IDLE edge that samples
// the request until the cycle where dready_n is low. That strobe lasts one cycle. A dreq seen in
// the following IDLE cycle starts a new access.
interface dmem_if;
  logic        dreq;
  logic        dwrite;
  logic [1:0]  dsize;
  logic [31:0] daddr;
  logic [31:0] input_ddata;
  logic [31:0] output_ddata;
  logic        dready_n;
  logic        dbusy;
  logic        dmisalign;

  modport master (
    output dreq, dwrite, dsize, daddr, input_ddata,
    input  output_ddata, dready_n, dbusy, dmisalign
  );

  modport slave (
    input  dreq, dwrite, dsize, daddr, input_ddata,
    output output_ddata, dready_n, dbusy, dmisalign
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data RAM with a programmable wait-state latency (IDLE -> WAIT -> RESP).
// Optional misaligned-access trap: define DMEM_MISALIGN_TRAP_EN.
module dmem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  dmem_if.slave      bus,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [1:0]          lane_q, lane_d;
  logic [1:0]          size_q, size_d;
  logic                write_q, write_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                rdy_n_q, rdy_n_d;
  logic                busy_q, busy_d;
  logic                mis_q, mis_d;

  logic [31:0]         mem [2**ADDR_W];

  logic                acc_mis;
  logic [31:0]         rd_word;
  logic [31:0]         rd_shift;
  logic [1:0]          st_lane;
  logic [3:0]          st_be;
  logic [31:0]         st_data;
  logic                unused_addr;

  // Lane actually used: halves drop addr[0], words drop addr[1:0].
  function automatic logic [1:0] eff_lane(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   return lane;
      2'b01:   return {lane[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  assign unused_addr = ^bus.daddr[31:ADDR_W+2];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    lane_d   = lane_q;
    size_d   = size_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    mis_d    = 1'b0;
    acc_mis  = 1'b0;
    rd_word  = '0;
    rd_shift = '0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.dreq) begin
          idx_d   = bus.daddr[ADDR_W+1:2];
          lane_d  = bus.daddr[1:0];
          size_d  = bus.dsize;
          write_d = bus.dwrite;
          wdata_d = bus.input_ddata;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

`ifdef DMEM_MISALIGN_TRAP_EN
    acc_mis = ((size_d == 2'b01) && lane_d[0]) || (size_d[1] && (lane_d != 2'b00));
`else
    acc_mis = 1'b0;
`endif

    // Load data is captured on the edge entering RESP so it is valid throughout the strobe.
    if ((state_d == S_RESP) && (state_q != S_RESP)) begin
      mis_d = acc_mis;
      if (!write_d) begin
        rd_word  = mem[idx_d];
        rd_shift = rd_word >> {eff_lane(size_d, lane_d), 3'b000};
        case (size_d)
          2'b00:   rdata_d = {24'h0, rd_shift[7:0]};
          2'b01:   rdata_d = {16'h0, rd_shift[15:0]};
          default: rdata_d = rd_shift;
        endcase
        if (acc_mis) rdata_d = '0;
      end
    end

    busy_d  = (state_d != S_IDLE);
    rdy_n_d = (state_d != S_RESP);
  end

  assign st_lane = eff_lane(size_q, lane_q);
  assign st_be   = (size_q == 2'b00) ? (4'b0001 << st_lane) :
                   (size_q == 2'b01) ? (4'b0011 << st_lane) : 4'b1111;
  assign st_data = wdata_q << {st_lane, 3'b000};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      lane_q  <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      rdy_n_q <= 1'b1;
      busy_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      size_q  <= size_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rdy_n_q <= rdy_n_d;
      busy_q  <= busy_d;
      mis_q   <= mis_d;
    end
  end

  // Store commits on the edge that ends RESP; a reset on that edge abandons it.
  always_ff @(posedge clk) begin
    if (!rst && (state_q == S_RESP) && write_q && !mis_q) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) mem[idx_q][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
  end

  assign bus.output_ddata = rdata_q;
  assign bus.dready_n     = rdy_n_q;
  assign bus.dbusy        = busy_q;
  assign bus.dmisalign    = mis_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (2 and 0 wait states) checked each cycle against a
// latency/RAM model, plus directed literal expectations.
module tb_dmem_responder;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req [2];
  logic        wr  [2];
  logic [1:0]  sz  [2];
  logic [31:0] ad  [2];
  logic [31:0] wd  [2];

  logic        rdy_n_a [2];
  logic        busy_a  [2];
  logic        mis_a   [2];
  logic [31:0] out_a   [2];

  logic [1:0]  unused_dbg0, unused_dbg1;

  dmem_if bus0();
  dmem_if bus1();

  assign bus0.dreq = req[0];  assign bus0.dwrite = wr[0];  assign bus0.dsize = sz[0];
  assign bus0.daddr = ad[0];  assign bus0.input_ddata = wd[0];
  assign bus1.dreq = req[1];  assign bus1.dwrite = wr[1];  assign bus1.dsize = sz[1];
  assign bus1.daddr = ad[1];  assign bus1.input_ddata = wd[1];

  assign rdy_n_a[0] = bus0.dready_n;  assign busy_a[0] = bus0.dbusy;
  assign mis_a[0]   = bus0.dmisalign; assign out_a[0]  = bus0.output_ddata;
  assign rdy_n_a[1] = bus1.dready_n;  assign busy_a[1] = bus1.dbusy;
  assign mis_a[1]   = bus1.dmisalign; assign out_a[1]  = bus1.output_ddata;

  dmem_responder #(.ADDR_W(AW), .WAIT_CYCLES(2)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .dbg_state(unused_dbg0)
  );
  dmem_responder #(.ADDR_W(AW), .WAIT_CYCLES(0)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .dbg_state(unused_dbg1)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          left   [2];
  bit          l_w    [2];
  logic [1:0]  l_s    [2];
  logic [31:0] l_a    [2];
  logic [31:0] l_d    [2];
  bit          l_mis  [2];
  logic [31:0] eo     [2];
  bit          eo_kn  [2];
  logic [31:0] mm     [2][0:(1<<AW)-1];
  bit          kn     [2][0:(1<<AW)-1];
  bit          mdl_live = 1'b0;

  function automatic bit mis_of(input logic [1:0] s, input logic [31:0] a);
`ifdef DMEM_MISALIGN_TRAP_EN
    return ((s == 2'b01) && a[0]) || (s[1] && (a[1:0] != 2'b00));
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] w, input logic [1:0] s, input logic [31:0] a);
    case (s)
      2'b00:   return (w >> (8 * a[1:0])) & 32'h0000_00FF;
      2'b01:   return (w >> (16 * a[1])) & 32'h0000_FFFF;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] store_val(input logic [31:0] old, input logic [1:0] s,
                                            input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    r = old;
    case (s)
      2'b00:   r[8*a[1:0] +: 8] = d[7:0];
      2'b01:   r[16*a[1] +: 16] = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'(a[AW+1:2]);
  endfunction

  function automatic void enter_resp(input int i);
    int k;
    k = idx_of(l_a[i]);
    if (!l_w[i]) begin
      if (l_mis[i]) begin
        eo[i] = '0; eo_kn[i] = 1'b1;
      end else begin
        eo[i] = load_val(mm[i][k], l_s[i], l_a[i]); eo_kn[i] = kn[i][k];
      end
    end
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int wc;
      int k;
      wc = (i == 0) ? 2 : 0;
      if (rst) begin
        left[i] = 0; eo[i] = '0; eo_kn[i] = 1'b1; l_mis[i] = 1'b0;
        mdl_live = 1'b1;
      end else if (left[i] == 0) begin
        if (req[i]) begin
          l_w[i] = wr[i]; l_s[i] = sz[i]; l_a[i] = ad[i]; l_d[i] = wd[i];
          l_mis[i] = mis_of(sz[i], ad[i]);
          left[i] = wc + 1;
          if (left[i] == 1) enter_resp(i);
        end
      end else if (left[i] == 1) begin
        if (l_w[i] && !l_mis[i]) begin
          k = idx_of(l_a[i]);
          if (l_s[i][1]) begin
            mm[i][k] = l_d[i]; kn[i][k] = 1'b1;
          end else if (kn[i][k]) begin
            mm[i][k] = store_val(mm[i][k], l_s[i], l_a[i], l_d[i]);
          end
        end
        left[i] = 0;
      end else begin
        left[i] = left[i] - 1;
        if (left[i] == 1) enter_resp(i);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (mdl_live) begin
      for (int i = 0; i < 2; i++) begin
        check32($sformatf("dbusy%0d", i), {31'h0, busy_a[i]}, {31'h0, left[i] > 0});
        check32($sformatf("dready_n%0d", i), {31'h0, rdy_n_a[i]}, {31'h0, left[i] != 1});
        check32($sformatf("dmisalign%0d", i), {31'h0, mis_a[i]}, {31'h0, (left[i] == 1) && l_mis[i]});
        if (eo_kn[i]) check32($sformatf("output_ddata%0d", i), out_a[i], eo[i]);
      end
    end
  end

  // ---------------- driver ----------------
  // Called at a falling edge; returns at the falling edge inside the strobe cycle.
  task automatic access(input int i, input bit w, input logic [1:0] s, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd, output int lat,
                        output int nbusy, output logic mis);
    req[i] = 1'b1; wr[i] = w; sz[i] = s; ad[i] = a; wd[i] = d;
    lat = 0; nbusy = 0; rd = '0; mis = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (busy_a[i]) nbusy++;
      if (rdy_n_a[i] == 1'b0) begin
        lat = k; rd = out_a[i]; mis = mis_a[i];
        break;
      end
    end
    if (lat == 0) begin
      n_checks++; n_errors++;
      $display("FAIL timeout inst%0d: got no strobe expected strobe within 40 cycles", i);
    end
    req[i] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd;
    int lat, nb;
    logic mis;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; wr[i] = 1'b0; sz[i] = 2'b00; ad[i] = '0; wd[i] = '0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check32("reset_dbusy", {31'h0, busy_a[0]}, 32'h0);
    check32("reset_dready_n", {31'h0, rdy_n_a[0]}, 32'h1);
    check32("reset_ddata", out_a[0], 32'h0);
    rst = 1'b0;
    idle(1);

    // Word store/load with 2 wait states.
    access(0, 1, 2'b10, 32'h10, 32'hDEADBEEF, rd, lat, nb, mis);
    check32("st_latency", lat, 3);
    check32("st_busy_cycles", nb, 3);
    idle(1);
    access(0, 0, 2'b10, 32'h10, 32'h0, rd, lat, nb, mis);
    check32("ld_latency", lat, 3);
    check32("ld_word", rd, 32'hDEADBEEF);

    // Byte lane update.
    idle(1); access(0, 1, 2'b10, 32'h10, 32'h11223344, rd, lat, nb, mis);
    idle(1); access(0, 1, 2'b00, 32'h11, 32'h000000AA, rd, lat, nb, mis);
    idle(1); access(0, 0, 2'b10, 32'h10, 32'h0, rd, lat, nb, mis);
    check32("byte_merge", rd, 32'h1122AA44);
    idle(1); access(0, 0, 2'b00, 32'h13, 32'h0, rd, lat, nb, mis);
    check32("byte_load", rd, 32'h00000011);

    // Half lane update.
    idle(1); access(0, 1, 2'b10, 32'h20, 32'h0, rd, lat, nb, mis);
    idle(1); access(0, 1, 2'b01, 32'h22, 32'h0000BEEF, rd, lat, nb, mis);
    idle(1); access(0, 0, 2'b10, 32'h20, 32'h0, rd, lat, nb, mis);
    check32("half_merge", rd, 32'hBEEF0000);
    idle(1); access(0, 0, 2'b01, 32'h22, 32'h0, rd, lat, nb, mis);
    check32("half_load", rd, 32'h0000BEEF);

    // Reset during WAIT abandons the store.
    idle(1); access(0, 1, 2'b10, 32'h30, 32'hCAFEF00D, rd, lat, nb, mis);
    idle(1);
    req[0] = 1'b1; wr[0] = 1'b1; sz[0] = 2'b10; ad[0] = 32'h30; wd[0] = 32'h5;
    @(negedge clk);
    check32("mid_busy", {31'h0, busy_a[0]}, 32'h1);
    rst = 1'b1; req[0] = 1'b0;
    @(negedge clk);
    check32("rst_busy_drop", {31'h0, busy_a[0]}, 32'h0);
    check32("rst_no_strobe", {31'h0, rdy_n_a[0]}, 32'h1);
    rst = 1'b0;
    idle(1); access(0, 0, 2'b10, 32'h30, 32'h0, rd, lat, nb, mis);
    check32("rst_old_value", rd, 32'hCAFEF00D);

    // Misaligned word store.
    idle(1); access(0, 1, 2'b10, 32'h40, 32'h0BADF00D, rd, lat, nb, mis);
    idle(1); access(0, 1, 2'b10, 32'h41, 32'h12345678, rd, lat, nb, mis);
`ifdef DMEM_MISALIGN_TRAP_EN
    check32("misalign_flag", {31'h0, mis}, 32'h1);
    idle(1); access(0, 0, 2'b10, 32'h40, 32'h0, rd, lat, nb, mis);
    check32("misalign_unchanged", rd, 32'h0BADF00D);
`else
    check32("misalign_flag", {31'h0, mis}, 32'h0);
    idle(1); access(0, 0, 2'b10, 32'h40, 32'h0, rd, lat, nb, mis);
    check32("misalign_written", rd, 32'h12345678);
`endif

    // Zero wait states: back-to-back traffic on instance 1.
    idle(1); access(1, 1, 2'b10, 32'h0, 32'h01020304, rd, lat, nb, mis);
    idle(1); access(1, 1, 2'b10, 32'h4, 32'hA5A55A5A, rd, lat, nb, mis);
    idle(1); access(1, 0, 2'b10, 32'h0, 32'h0, rd, lat, nb, mis);
    check32("w0_first_latency", lat, 1);
    check32("w0_load0", rd, 32'h01020304);
    access(1, 0, 2'b10, 32'h4, 32'h0, rd, lat, nb, mis);
    check32("w0_strobe_period", lat, 2);
    check32("w0_load4", rd, 32'hA5A55A5A);
    access(1, 1, 2'b10, 32'h8, 32'h5555AAAA, rd, lat, nb, mis);
    access(1, 0, 2'b10, 32'h8, 32'h0, rd, lat, nb, mis);
    check32("st_ld_b2b", rd, 32'h5555AAAA);

    // Randomized traffic over word indices 64..79, with upper address bits scrambled.
    for (int i = 0; i < 2; i++) begin
      for (int k = 64; k < 80; k++) begin
        idle(1);
        access(i, 1, 2'b10, 32'(k * 4), $urandom, rd, lat, nb, mis);
      end
      for (int n = 0; n < 150; n++) begin
        logic [31:0] a;
        a = $urandom;
        a[AW+1:2] = AW'(64 + $urandom_range(0, 15));
        idle($urandom_range(0, 2));
        access(i, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom,
               rd, lat, nb, mis);
      end
      idle(1);
    end

    idle(3);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish before 2ms");
    $fatal(1);
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder (target side) for the MEM-stage data bus: daddr/dreq/dwrite/dsize/input_ddata in, output_ddata/dready_n/dbusy out.
- Holds a word-organised synchronous RAM.
- Adds a programmable access latency so stalls on dready_n/dbusy in the pipeline are exercised.
- Sits beside the core in the top-level, replacing the external data memory model.

Parameters:
- ADDR_W, 10, word-index width; RAM depth is 2^ADDR_W 32-bit words.
- WAIT_CYCLES, 2, extra wait-state cycles per access (0..15).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- dreq  in  1  access request
- dwrite  in  1  1 = store, 0 = load
- dsize  in  2  00 byte, 01 half, 10 word; 11 is treated as word
- daddr  in  32  byte address
- input_ddata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- output_ddata  out  32  load data, right-aligned, not extended; the core performs sign/zero extension
- dready_n  out  1  active-low one-cycle completion strobe
- dbusy  out  1  access in progress
- dmisalign  out  1  one-cycle misaligned-access flag; only with the optional feature

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state IDLE, dbusy 0, dready_n 1, output_ddata 0, dmisalign 0, wait counter 0. RAM contents are not cleared.
- Reset mid-access: the access is abandoned, with no RAM write and no strobe.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If dreq=1 at an edge, latch daddr, dsize, dwrite and input_ddata.
  - Load counter with WAIT_CYCLES.
  - Go to WAIT if WAIT_CYCLES>0, else go to RESP.
- WAIT:
  - Counter decrements each cycle; go to RESP when counter reaches 1.
  - Inputs are ignored.
- RESP:
  - Lasts one cycle with dready_n=0.
  - Return to IDLE.
- dbusy=1 in WAIT and RESP, 0 in IDLE.
- Latency: request sampled at edge T gives dready_n=0 during cycle T+1+WAIT_CYCLES.
- Requester handshake: hold dreq and all request signals stable until the dready_n=0 cycle. The next cycle's dreq in IDLE is a new request, so back-to-back accesses are allowed.
- Word index is latched daddr[ADDR_W+1:2]; upper bits are ignored, so addresses wrap modulo 2^(ADDR_W+2) bytes. Lane is daddr[1:0].
- Store:
  - RAM is written at the edge that ends RESP.
  - Byte: input_ddata[7:0] is written to lane 8*addr[1:0].
  - Half: input_ddata[15:0] is written to lanes addr[1]*16.
  - Word: all 32 bits are written.
  - Byte enables apply; other bytes are preserved.
  - output_ddata is unchanged by stores.
- Load:
  - output_ddata = RAM word shifted right by 8*addr[1:0] (byte/half) and masked to size; upper bits are 0.
  - Valid during the dready_n=0 cycle and held until the next load response.
- Misalignment without the optional feature: half ignores addr[0]; word ignores addr[1:0].
- Back-to-back store then load to the same word must return the new data.

Optional Feature:
- Macro DMEM_MISALIGN_TRAP_EN.
- When defined, misalignment is detected on the latched request: half with addr[0]=1, or word with addr[1:0]≠0.
  - The response still completes with normal latency.
  - dmisalign=1 in the RESP cycle.
  - Stores are suppressed (RAM unchanged).
  - Loads return 0.
- When undefined, dmisalign is tied 0 and the alignment-masking rule applies.

Test Plan:
- Reset, then WAIT_CYCLES=2: word store 0xDEADBEEF @0x10, then word load @0x10. Each access gives dready_n=0 exactly 3 cycles after the dreq edge, with dbusy high for those 3 cycles. Load returns 0xDEADBEEF.
- Byte store 0xAA @0x11 over 0x11223344, then word load @0x10 returns 0x1122AA44. Byte load @0x13 returns 0x00000011.
- Half store 0xBEEF @0x22 over 0, then word load @0x20 returns 0xBEEF0000. Half load @0x22 returns 0x0000BEEF.
- WAIT_CYCLES=0: back-to-back loads @0x0 and @0x4 give a dready_n strobe every 2 cycles with correct data each time.
- Assert rst during WAIT of a store of 0x5 @0x30. dbusy drops the next cycle, with no strobe. A later load @0x30 returns the old value.
- With DMEM_MISALIGN_TRAP_EN: word store @0x41 gives dmisalign=1 in the strobe cycle and the RAM word @0x40 is unchanged. Without the macro, the same store writes the full word @0x40.
